// File: rtl/ov7670_fb_writer.sv
// Camera pixel stream to linear framebuffer writer: synchronises vsync/newPixel,
// generates raster addresses, buffers writes in a small FIFO and drives a req/ack
// memory port. Optional double buffering is enabled with `OV7670_FB_DOUBLE_BUFFER_EN`.
module ov7670_fb_writer #(
  parameter int unsigned WIDTH      = 320,
  parameter int unsigned HEIGHT     = 240,
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              newPixel,
  input  logic [15:0]       pixelData,
  output logic              memWrReq,
  output logic [ADDR_W-1:0] memWrAddr,
  output logic [15:0]       memWrData,
  input  logic              memWrAck,
  output logic              frameDone,
  output logic              overflow,
  output logic              displayBank
);
  localparam int unsigned NPIX  = WIDTH * HEIGHT;
  localparam int unsigned IDX_W = $clog2(NPIX + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W = 1 + ADDR_W + 16;
  localparam logic [IDX_W-1:0]  NPIX_I = IDX_W'(NPIX);
  localparam logic [IDX_W-1:0]  LAST_I = IDX_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] NPIX_A = ADDR_W'(NPIX);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  logic vs_s1_q, vs_s2_q, vs_s3_q, vs_rise_q;
  logic np_s1_q, np_s2_q, np_s3_q, pix_strobe_q;
  logic vs_rise_d, pix_strobe_d;
  logic [15:0] pix_hold_q, pix_hold_d;

  logic armed_q, armed_d, ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic bank;

  logic [ENT_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic full, empty, push, pop;
  logic [ADDR_W-1:0] push_addr;

  state_t state_q, state_d;
  logic req_q, req_d, last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;

`ifdef OV7670_FB_DOUBLE_BUFFER_EN
  logic bank_q, bank_d, disp_bank_q, disp_bank_d;
  assign bank        = bank_q;
  assign displayBank = disp_bank_q;
`else
  assign bank        = 1'b0;
  assign displayBank = 1'b0;
`endif

  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push_addr = ADDR_W'(idx_q) + (bank ? NPIX_A : '0);

  // Edge detectors are registered so vsRise/pixStrobe and the captured pixel align.
  always_comb begin
    vs_rise_d    = vs_s2_q & ~vs_s3_q;
    pix_strobe_d = np_s2_q & ~np_s3_q;
    pix_hold_d   = pix_strobe_d ? pixelData : pix_hold_q;
  end

  always_comb begin
    armed_d = armed_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
`ifdef OV7670_FB_DOUBLE_BUFFER_EN
    bank_d  = bank_q;
`endif
    if (vs_rise_q) begin
      idx_d   = '0;
      ovf_d   = 1'b0;
      armed_d = 1'b1;
`ifdef OV7670_FB_DOUBLE_BUFFER_EN
      if (armed_q) bank_d = ~bank_q;
`endif
    end else if (pix_strobe_q && armed_q && (idx_q < NPIX_I)) begin
      idx_d = idx_q + 1'b1;
      if (full) ovf_d = 1'b1;
      else      push  = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    data_d    = data_q;
    last_d    = last_q;
    pop       = 1'b0;
    frameDone = 1'b0;
`ifdef OV7670_FB_DOUBLE_BUFFER_EN
    disp_bank_d = disp_bank_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          {last_d, addr_d, data_d} = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
          req_d   = 1'b1;
          pop     = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (memWrAck) begin
          req_d     = 1'b0;
          state_d   = S_IDLE;
          frameDone = last_q;
`ifdef OV7670_FB_DOUBLE_BUFFER_EN
          if (last_q) disp_bank_d = (addr_q >= NPIX_A);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q[PTR_W-1:0]] = {(idx_q == LAST_I), push_addr, pix_hold_q};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {vs_s1_q, vs_s2_q, vs_s3_q, vs_rise_q}        <= '0;
      {np_s1_q, np_s2_q, np_s3_q, pix_strobe_q}     <= '0;
      pix_hold_q <= '0;
      armed_q    <= 1'b0;
      idx_q      <= '0;
      ovf_q      <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
`ifdef OV7670_FB_DOUBLE_BUFFER_EN
      bank_q      <= 1'b0;
      disp_bank_q <= 1'b0;
`endif
    end else begin
      vs_s1_q      <= vsync;
      vs_s2_q      <= vs_s1_q;
      vs_s3_q      <= vs_s2_q;
      vs_rise_q    <= vs_rise_d;
      np_s1_q      <= newPixel;
      np_s2_q      <= np_s1_q;
      np_s3_q      <= np_s2_q;
      pix_strobe_q <= pix_strobe_d;
      pix_hold_q   <= pix_hold_d;
      armed_q      <= armed_d;
      idx_q        <= idx_d;
      ovf_q        <= ovf_d;
      fifo_mem_q   <= fifo_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      last_q       <= last_d;
`ifdef OV7670_FB_DOUBLE_BUFFER_EN
      bank_q      <= bank_d;
      disp_bank_q <= disp_bank_d;
`endif
    end
  end

  assign memWrReq  = req_q;
  assign memWrAddr = addr_q;
  assign memWrData = data_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_ov7670_fb_writer.sv
// Scoreboard bench for ov7670_fb_writer on a 4x2 frame: stimulus queues expected
// writes, a negedge monitor acks requests and compares them in order.
module tb_ov7670_fb_writer;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned NP = W * H;
`ifdef OV7670_FB_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, vsync, newPixel, memWrAck;
  logic [15:0] pixelData;
  logic        memWrReq, frameDone, overflow, displayBank;
  logic [17:0] memWrAddr;
  logic [15:0] memWrData;

  ov7670_fb_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(18), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .newPixel(newPixel),
    .pixelData(pixelData), .memWrReq(memWrReq), .memWrAddr(memWrAddr),
    .memWrData(memWrData), .memWrAck(memWrAck), .frameDone(frameDone),
    .overflow(overflow), .displayBank(displayBank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
    bit          last;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          ack_en   = 1'b1;
  bit          armed_m  = 1'b0;
  bit          bank_m   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] exp_addr(input int unsigned idx);
    return 18'(bank_m * NP + idx);
  endfunction

  // Monitor/responder: acks each request one cycle after it appears.
  exp_t mon_e;
  bit   mon_last;
  always @(negedge clk) begin
    if (memWrReq && !memWrAck && ack_en && !reset) begin
      mon_last = 1'b0;
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                 memWrAddr, memWrData);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", 32'(memWrAddr), 32'(mon_e.addr));
        check("wr_data", 32'(memWrData), 32'(mon_e.data));
        mon_last = mon_e.last;
      end
      memWrAck = 1'b1;
      #1;
      check("frame_done", 32'(frameDone), 32'(mon_last));
    end else begin
      memWrAck = 1'b0;
    end
  end

  task automatic pulse_vsync();
    @(negedge clk);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    if (armed_m && DB) bank_m = ~bank_m;
    armed_m = 1'b1;
  endtask

  task automatic send_pix(input logic [15:0] d, input bit wr, input int unsigned idx);
    exp_t e;
    if (wr) begin
      e.addr = exp_addr(idx);
      e.data = d;
      e.last = (idx == NP - 1);
      sb.push_back(e);
    end
    @(negedge clk);
    pixelData = d;
    newPixel  = 1'b1;
    repeat (4) @(negedge clk);
    newPixel = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_drain();
    int unsigned k = 0;
    while ((sb.size() != 0 || memWrReq) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; vsync = 1'b0; newPixel = 1'b0; pixelData = '0; memWrAck = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(memWrReq), 32'd0);
    check("rst_addr", 32'(memWrAddr), 32'd0);
    check("rst_data", 32'(memWrData), 32'd0);
    check("rst_frame_done", 32'(frameDone), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_display_bank", 32'(displayBank), 32'd0);
    reset = 1'b0;

    // Disarmed: strobes before the first vsync must not write.
    send_pix(16'h0BAD, 1'b0, 0);
    send_pix(16'h0BAE, 1'b0, 0);
    repeat (10) @(negedge clk);

    pulse_vsync();
    // Basic, with latency measured from the newPixel edge.
    e.addr = exp_addr(0); e.data = 16'h1111; e.last = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    pixelData = 16'h1111;
    newPixel  = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("lat_req_cycle4", 32'(memWrReq), 32'd0);
    @(posedge clk);
    #1 check("lat_req_cycle5", 32'(memWrReq), 32'd1);
    @(negedge clk);
    newPixel = 1'b0;
    repeat (4) @(negedge clk);
    send_pix(16'h2222, 1'b1, 1);
    send_pix(16'h3333, 1'b1, 2);
    send_pix(16'h4444, 1'b1, 3);
    wait_drain();
    check("basic_overflow", 32'(overflow), 32'd0);

    // Mid-frame vsync restarts the index; coincident vsync+strobe drops the strobe.
    pulse_vsync();
    for (int i = 0; i < 3; i++) send_pix(16'h5001 + 16'(i), 1'b1, i);
    pulse_vsync();
    send_pix(16'h5100, 1'b1, 0);
    @(negedge clk);
    vsync = 1'b1; newPixel = 1'b1; pixelData = 16'hDEAD;
    repeat (4) @(negedge clk);
    vsync = 1'b0; newPixel = 1'b0;
    repeat (4) @(negedge clk);
    if (DB) bank_m = ~bank_m;
    send_pix(16'h5200, 1'b1, 0);
    wait_drain();

    // Back-pressure: one write in flight plus four queued, sixth pixel dropped.
    pulse_vsync();
    ack_en = 1'b0;
    for (int i = 0; i < 6; i++) send_pix(16'hA000 + 16'(i), (i < 5), i);
    repeat (4) @(negedge clk);
    check("bp_overflow_set", 32'(overflow), 32'd1);
    check("bp_req_held", 32'(memWrReq), 32'd1);
    check("bp_addr_held", 32'(memWrAddr), 32'(exp_addr(0)));
    check("bp_data_held", 32'(memWrData), 32'h0000A000);
    ack_en = 1'b1;
    wait_drain();
    send_pix(16'hA006, 1'b1, 6);
    wait_drain();
    check("bp_overflow_sticky", 32'(overflow), 32'd1);
    pulse_vsync();
    check("bp_overflow_cleared", 32'(overflow), 32'd0);

    // Reset mid-write abandons the in-flight write and the queued entries.
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) send_pix(16'hB000 + 16'(i), 1'b0, i);
    check("rmw_req_before", 32'(memWrReq), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1 check("rmw_req_async", 32'(memWrReq), 32'd0);
    armed_m = 1'b0;
    bank_m  = 1'b0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    ack_en = 1'b1;
    send_pix(16'hB100, 1'b0, 0);
    send_pix(16'hB101, 1'b0, 0);
    repeat (10) @(negedge clk);

    // Two full frames; extra strobes past the last pixel are ignored.
    pulse_vsync();
    for (int i = 0; i < 10; i++) send_pix(16'hC000 + 16'(i), (i < NP), i);
    wait_drain();
    check("frame1_display_bank", 32'(displayBank), 32'(bank_m));
    check("frame1_overflow", 32'(overflow), 32'd0);
    pulse_vsync();
    for (int i = 0; i < 8; i++) send_pix(16'hD000 + 16'(i), 1'b1, i);
    wait_drain();
    check("frame2_display_bank", 32'(displayBank), 32'(bank_m));

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
